// File: rtl/multiply_seq.sv
// Sequential radix-2 shift-add multiplier with per-operand signed/unsigned mode.
// Works on operand magnitudes and applies the result sign once at the end.
module multiply_seq #(
    parameter int p_width = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [p_width-1:0]     a_i,
    input  logic [p_width-1:0]     b_i,
    input  logic                   a_signed_i,
    input  logic                   b_signed_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [2*p_width-1:0]   product_o
);

    // state | meaning
    // IDLE  | waiting for valid_i, ready_o high
    // BUSY  | one multiplier bit consumed per cycle, p_width cycles
    // DONE  | product_o valid, held until ready_i
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int cnt_w = $clog2(p_width) + 1;

    state_t                 state_q, state_d;
    logic                   ready_q, ready_d;
    logic                   valid_q, valid_d;
    logic [cnt_w-1:0]       cnt_q, cnt_d;
    logic [2*p_width-1:0]   a_sh_q, a_sh_d;
    logic [p_width-1:0]     b_sh_q, b_sh_d;
    logic                   neg_q, neg_d;
    logic [2*p_width-1:0]   acc_q, acc_d;
    logic [2*p_width-1:0]   product_q, product_d;

    logic                   a_neg, b_neg;
    logic [p_width-1:0]     a_abs, b_abs;
    logic [2*p_width-1:0]   acc_sum;

    always_comb begin
        a_neg = a_signed_i & a_i[p_width-1];
        b_neg = b_signed_i & b_i[p_width-1];
        // Negating -2^(p_width-1) yields 2^(p_width-1), which is the correct unsigned magnitude.
        a_abs = a_neg ? -a_i : a_i;
        b_abs = b_neg ? -b_i : b_i;
        acc_sum = acc_q + (b_sh_q[0] ? a_sh_q : '0);

        state_d   = state_q;
        ready_d   = ready_q;
        valid_d   = valid_q;
        cnt_d     = cnt_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        neg_d     = neg_q;
        acc_d     = acc_q;
        product_d = product_q;

        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    a_sh_d  = {{p_width{1'b0}}, a_abs};
                    b_sh_d  = b_abs;
                    neg_d   = a_neg ^ b_neg;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d  = acc_sum;
                a_sh_d = a_sh_q << 1;
                b_sh_d = b_sh_q >> 1;
                cnt_d  = cnt_q + cnt_w'(1);
                if (cnt_q == cnt_w'(p_width - 1)) begin
                    product_d = neg_q ? -acc_sum : acc_sum;
                    valid_d   = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (ready_i) begin
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            cnt_q     <= '0;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            neg_q     <= 1'b0;
            acc_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            neg_q     <= neg_d;
            acc_q     <= acc_d;
            product_q <= product_d;
        end
    end

    assign ready_o   = ready_q;
    assign valid_o   = valid_q;
    assign product_o = product_q;

endmodule
